// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : Decode/execute pipeline register feeding the ALU. Captures
//               decoded operands, immediate and control; forwards results
//               from EX/MEM and MEM/WB onto the operand outputs; detects
//               load-use hazards, requests a front-end stall and inserts a
//               bubble into execute.
// Ports       : clk, rst                      - clock, sync active-high reset
//               id_*                          - decoded instruction fields
//               flush, hold                   - squash / global freeze
//               exm_*, wb_*                   - forwarding sources
//               ALUop1, regOp2, ImmOp,
//               ALUctrl, ALUsrc               - ALU operands and control
//               ex_valid, ex_rd, ex_reg_write,
//               ex_mem_read, ex_mem_write     - registered execute control
//               load_use_stall                - combinational stall request
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATAWIDTH = 32,
  parameter int REGADDR   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REGADDR-1:0]   id_rs1,
  input  logic [REGADDR-1:0]   id_rs2,
  input  logic [REGADDR-1:0]   id_rd,
  input  logic [DATAWIDTH-1:0] id_rs1_data,
  input  logic [DATAWIDTH-1:0] id_rs2_data,
  input  logic [DATAWIDTH-1:0] id_imm,
  input  logic [2:0]           id_alu_ctrl,
  input  logic                 id_alu_src,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic                 flush,
  input  logic                 hold,
  input  logic [REGADDR-1:0]   exm_rd,
  input  logic                 exm_reg_write,
  input  logic [DATAWIDTH-1:0] exm_result,
  input  logic [REGADDR-1:0]   wb_rd,
  input  logic                 wb_reg_write,
  input  logic [DATAWIDTH-1:0] wb_result,
  output logic [DATAWIDTH-1:0] ALUop1,
  output logic [DATAWIDTH-1:0] regOp2,
  output logic [DATAWIDTH-1:0] ImmOp,
  output logic [2:0]           ALUctrl,
  output logic                 ALUsrc,
  output logic                 ex_valid,
  output logic [REGADDR-1:0]   ex_rd,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 load_use_stall
);

  localparam logic [REGADDR-1:0] c_x0 = '0;

  // Everything held in the execute slot. Source indices are kept so that
  // forwarding can be resolved against the later pipeline stages.
  typedef struct packed {
    logic                 valid;
    logic [REGADDR-1:0]   rs1;
    logic [REGADDR-1:0]   rs2;
    logic [REGADDR-1:0]   rd;
    logic [DATAWIDTH-1:0] rs1_data;
    logic [DATAWIDTH-1:0] rs2_data;
    logic [DATAWIDTH-1:0] imm;
    logic [2:0]           alu_ctrl;
    logic                 alu_src;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
  } ex_fields_t;

  ex_fields_t ex_q;
  ex_fields_t ex_d;
  ex_fields_t w_id_fields;

  always_comb begin
    w_id_fields.valid     = id_valid;
    w_id_fields.rs1       = id_rs1;
    w_id_fields.rs2       = id_rs2;
    w_id_fields.rd        = id_rd;
    w_id_fields.rs1_data  = id_rs1_data;
    w_id_fields.rs2_data  = id_rs2_data;
    w_id_fields.imm       = id_imm;
    w_id_fields.alu_ctrl  = id_alu_ctrl;
    w_id_fields.alu_src   = id_alu_src;
    w_id_fields.reg_write = id_reg_write;
    w_id_fields.mem_read  = id_mem_read;
    w_id_fields.mem_write = id_mem_write;
  end

  // A load in execute whose destination is read by the instruction in
  // decode. Not gated by hold: the front end has to stall regardless.
  always_comb begin
    load_use_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != c_x0) &&
                     id_valid && ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
  end

  // Next-state priority: flush, hold, load-use bubble, capture.
  // A bubble clears the whole slot, data fields included.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (load_use_stall) begin
      ex_d = '0;
    end else begin
      ex_d = w_id_fields;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Operand forwarding. EX/MEM is the younger result and wins over MEM/WB.
  // x0 never forwards because its architectural value is constant.
  always_comb begin
    ALUop1 = ex_q.rs1_data;
    if (exm_reg_write && (exm_rd != c_x0) && (exm_rd == ex_q.rs1)) begin
      ALUop1 = exm_result;
    end else if (wb_reg_write && (wb_rd != c_x0) && (wb_rd == ex_q.rs1)) begin
      ALUop1 = wb_result;
    end
  end

  always_comb begin
    regOp2 = ex_q.rs2_data;
    if (exm_reg_write && (exm_rd != c_x0) && (exm_rd == ex_q.rs2)) begin
      regOp2 = exm_result;
    end else if (wb_reg_write && (wb_rd != c_x0) && (wb_rd == ex_q.rs2)) begin
      regOp2 = wb_result;
    end
  end

  always_comb begin
    ImmOp        = ex_q.imm;
    ALUctrl      = ex_q.alu_ctrl;
    ALUsrc       = ex_q.alu_src;
    ex_valid     = ex_q.valid;
    ex_rd        = ex_q.rd;
    ex_reg_write = ex_q.reg_write;
    ex_mem_read  = ex_q.mem_read;
    ex_mem_write = ex_q.mem_write;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/execute pipeline register that directly feeds the ALU operand and control inputs.
- Captures decoded operands, immediate and control each cycle.
- Resolves RAW data hazards by forwarding results from the EX/MEM and MEM/WB stages.
- Detects load-use hazards, requests a front-end stall and inserts a bubble into execute.

Parameters:
- DATAWIDTH, 32, datapath width.
- REGADDR, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1, id_rs2, id_rd  in  REGADDR each  source and destination indices.
- id_rs1_data, id_rs2_data  in  DATAWIDTH each  register-file read data.
- id_imm  in  DATAWIDTH  sign-extended immediate.
- id_alu_ctrl  in  3  ALU operation (000 add, 001 sub, 010 and).
- id_alu_src  in  1  1 selects immediate as the second ALU operand.
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits.
- flush  in  1  branch-taken squash.
- hold  in  1  global freeze (memory wait).
- exm_rd  in  REGADDR  EX/MEM destination.
- exm_reg_write  in  1  EX/MEM writes a register.
- exm_result  in  DATAWIDTH  EX/MEM ALU result.
- wb_rd  in  REGADDR  MEM/WB destination.
- wb_reg_write  in  1  MEM/WB writes a register.
- wb_result  in  DATAWIDTH  MEM/WB write-back data.
- ALUop1  out  DATAWIDTH  forwarded rs1 operand.
- regOp2  out  DATAWIDTH  forwarded rs2 operand.
- ImmOp  out  DATAWIDTH  registered immediate.
- ALUctrl  out  3  registered ALU control.
- ALUsrc  out  1  registered operand select.
- ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write  out  registered control (ex_rd is REGADDR wide, others 1).
- load_use_stall  out  1  combinational request to hold the PC and IF/ID.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset state: every registered field is 0. This gives ALUop1 = 0, regOp2 = 0, ImmOp = 0, ALUctrl = 000, ALUsrc = 0 and all ex_* = 0.
- Update priority at each rising edge:
  1. rst
  2. flush (load bubble)
  3. hold (keep all fields)
  4. load_use_stall (load bubble)
  5. otherwise capture all id_* fields.
- Bubble definition: ex_valid, ex_reg_write, ex_mem_read and ex_mem_write are all 0. Data fields are don't-care but are driven to 0.
- Latency: an instruction presented in decode appears on the ALU-side outputs one cycle later.
- Load-use detection: load_use_stall = ex_valid & ex_mem_read & ex_rd != 0 & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
  - Fully combinational.
  - Asserted regardless of hold; the front end must stall anyway.
  - Deasserts the cycle after the bubble is inserted, so a load-use pair stalls exactly 1 cycle.
- Forwarding (combinational from the registered ex_rs1/ex_rs2/data, evaluated per operand):
  - If exm_reg_write & exm_rd != 0 & exm_rd == ex_rs: use exm_result.
  - Else if wb_reg_write & wb_rd != 0 & wb_rd == ex_rs: use wb_result.
  - Else use the registered register-file data.
  - EX/MEM has priority over MEM/WB when both match.
  - x0 is never forwarded; an operand indexed by x0 always yields its registered data.
- regOp2 is always the forwarded rs2 value, independent of ALUsrc. The ALU selects between regOp2 and ImmOp itself.
- Forwarding stays live during hold: outputs track the changing exm_* and wb_* inputs while the registers are frozen.
- Widths: no arithmetic in this block; all data passes through at full DATAWIDTH.
- flush and load_use_stall in the same cycle: one bubble is inserted. The stall request still asserts if its conditions hold.
- rst mid-stall: all state clears on the next edge and load_use_stall drops to 0.

Test Plan:
- Reset, then id_valid = 1, id_rs1_data = 5, id_rs2_data = 7, id_imm = 12, id_alu_ctrl = 001, id_alu_src = 1 -> next cycle ALUop1 = 5, regOp2 = 7, ImmOp = 12, ALUctrl = 001, ALUsrc = 1, ex_valid = 1.
- EX holds rs1 = 3; exm_rd = 3, exm_reg_write = 1, exm_result = 0xAA; wb_rd = 3, wb_reg_write = 1, wb_result = 0xBB -> ALUop1 = 0xAA. Drop exm_reg_write -> ALUop1 = 0xBB.
- EX holds rs2 = 0; exm_rd = 0, exm_reg_write = 1, exm_result = 0xFF; registered rs2 data = 0 -> regOp2 = 0 (x0 not forwarded).
- Load in EX with ex_rd = 4, decode id_rs2 = 4, id_valid = 1 -> load_use_stall = 1 for exactly one cycle. Next cycle ex_valid = 0 and ex_mem_read = 0. Re-presented instruction is captured the cycle after.
- hold = 1 for 3 cycles while id_* changes -> all ex_* fields and ImmOp stay unchanged. flush = 1 together with hold = 1 -> bubble, ex_valid = 0.
- rst asserted while load_use_stall = 1 -> next edge: all outputs 0 and load_use_stall = 0.
